// File: rtl/mac_accum.sv
// mac_accum -- frame accumulator for the shift-add multiplier output stream.
//
// Sums N_TERMS unsigned products into an ACC_W = PROD_W+GUARD bit accumulator.
// When a frame completes, the sum is presented on out_acc/out_ovf with a
// valid/ready handshake. Input is stalled while a finished frame waits.
//
// Build option: define MAC_ACCUM_SAT_EN to saturate the accumulator to all
// ones on overflow. Without it, the accumulator wraps modulo 2^ACC_W.
// out_ovf reports overflow in both builds.
//
// Ports:
//   clk       rising-edge clock
//   rst_n     asynchronous active-low reset
//   clear     synchronous frame abort; overrides every handshake
//   in_valid  in_prod carries a product this cycle
//   in_ready  block accepts in_prod this cycle
//   in_prod   unsigned product, PROD_W bits
//   out_valid out_acc/out_ovf hold a completed frame
//   out_ready downstream takes the frame
//   out_acc   frame sum, ACC_W bits (keeps its value after the handshake)
//   out_ovf   frame overflowed ACC_W bits
module mac_accum #(
  parameter int unsigned PROD_W  = 512,
  parameter int unsigned GUARD   = 16,
  parameter int unsigned N_TERMS = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clear,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [PROD_W-1:0]       in_prod,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [PROD_W+GUARD-1:0] out_acc,
  output logic                    out_ovf
);

  localparam int unsigned ACC_W = PROD_W + GUARD;
  localparam int unsigned CNT_W = 16;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_TERMS - 1);

  typedef enum logic {
    ST_ACC,
    ST_OUT
  } state_t;

  state_t           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic             out_valid_q, out_valid_d;
  logic [ACC_W-1:0] out_acc_q, out_acc_d;
  logic             out_ovf_q, out_ovf_d;

  logic [ACC_W:0]   sum;
  logic [ACC_W-1:0] acc_next;
  logic             ovf_next;
  logic             xfer;

  // One extra bit on the adder captures the carry out of ACC_W.
  always_comb begin
    sum      = {1'b0, acc_q} + (ACC_W+1)'(in_prod);
    ovf_next = ovf_q | sum[ACC_W];
`ifdef MAC_ACCUM_SAT_EN
    // Sticky flag keeps the accumulator pinned once it has saturated.
    acc_next = ovf_next ? '1 : sum[ACC_W-1:0];
`else
    acc_next = sum[ACC_W-1:0];
`endif
  end

  // in_ready is forced low during reset, even though the state register already reads ACC.
  assign in_ready  = rst_n && (state_q == ST_ACC) && !clear;
  assign xfer      = in_valid && in_ready;
  assign out_valid = out_valid_q;
  assign out_acc   = out_acc_q;
  assign out_ovf   = out_ovf_q;

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    ovf_d       = ovf_q;
    out_valid_d = out_valid_q;
    out_acc_d   = out_acc_q;
    out_ovf_d   = out_ovf_q;

    // clear overrides everything. out_acc is left untouched because only out_valid qualifies it.
    if (clear) begin
      state_d     = ST_ACC;
      acc_d       = '0;
      cnt_d       = '0;
      ovf_d       = 1'b0;
      out_valid_d = 1'b0;
    end else begin
      case (state_q)
        ST_ACC: begin
          if (xfer) begin
            acc_d = acc_next;
            ovf_d = ovf_next;
            if (cnt_q == LAST_CNT) begin
              out_acc_d   = acc_next;
              out_ovf_d   = ovf_next;
              out_valid_d = 1'b1;
              state_d     = ST_OUT;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
        end
        ST_OUT: begin
          if (out_ready) begin
            acc_d       = '0;
            cnt_d       = '0;
            ovf_d       = 1'b0;
            out_valid_d = 1'b0;
            state_d     = ST_ACC;
          end
        end
        default: state_d = ST_ACC;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_ACC;
      acc_q       <= '0;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_acc_q   <= '0;
      out_ovf_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      ovf_q       <= ovf_d;
      out_valid_q <= out_valid_d;
      out_acc_q   <= out_acc_d;
      out_ovf_q   <= out_ovf_d;
    end
  end

endmodule

// File: tb/tb_mac_accum.sv
// tb_mac_accum -- scoreboard bench for mac_accum.
// A default-parameter instance is driven with directed and random traffic.
// It is compared against a frame-level arithmetic model.
// A second instance (GUARD=0, N_TERMS=2) exercises the overflow path.
module tb_mac_accum;

  localparam int PROD_W  = 512;
  localparam int GUARD   = 16;
  localparam int N_TERMS = 16;
  localparam int ACC_W   = PROD_W + GUARD;
  localparam int WIDE    = ACC_W + 16;
`ifdef MAC_ACCUM_SAT_EN
  localparam bit SAT_EN = 1'b1;
`else
  localparam bit SAT_EN = 1'b0;
`endif

  logic              clk;
  logic              rst_n;
  logic              clear;
  logic              in_valid;
  logic              in_ready;
  logic [PROD_W-1:0] in_prod;
  logic              out_valid;
  logic              out_ready;
  logic [ACC_W-1:0]  out_acc;
  logic              out_ovf;

  logic              o_clear;
  logic              o_in_valid;
  logic              o_in_ready;
  logic [PROD_W-1:0] o_in_prod;
  logic              o_out_valid;
  logic              o_out_ready;
  logic [PROD_W-1:0] o_out_acc;
  logic              o_out_ovf;

  int errors = 0;
  int checks = 0;

  mac_accum #(.PROD_W(PROD_W), .GUARD(GUARD), .N_TERMS(N_TERMS)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready), .in_prod(in_prod),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_acc(out_acc), .out_ovf(out_ovf)
  );

  mac_accum #(.PROD_W(PROD_W), .GUARD(0), .N_TERMS(2)) dut_ovf (
    .clk(clk), .rst_n(rst_n), .clear(o_clear),
    .in_valid(o_in_valid), .in_ready(o_in_ready), .in_prod(o_in_prod),
    .out_valid(o_out_valid), .out_ready(o_out_ready),
    .out_acc(o_out_acc), .out_ovf(o_out_ovf)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic void checkOutput(input string name, input logic [WIDE-1:0] actual,
                                      input logic [WIDE-1:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endfunction

  function automatic void timeoutFail(input string name);
    checks++;
    errors++;
    $display("[TB] FAIL %s: wait bound expired", name);
  endfunction

  // Reference model: a frame is just the plain sum of its accepted products.
  typedef struct {
    logic [ACC_W-1:0] acc;
    logic             ovf;
  } exp_t;

  exp_t             exp_q[$];
  logic [WIDE-1:0]  m_total;
  int               m_cnt;
  bit               m_out;
  logic [ACC_W-1:0] m_last_acc;
  bit               m_last_known;
  int               dut_frames = 0;

  function automatic exp_t refFrame(input logic [WIDE-1:0] total);
    exp_t e;
    e.ovf = (total >> ACC_W) != 0;
    e.acc = (e.ovf && SAT_EN) ? {ACC_W{1'b1}} : total[ACC_W-1:0];
    return e;
  endfunction

  // Monitor: sampled mid-cycle, so it sees what the next rising edge will act on.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      m_total      = '0;
      m_cnt        = 0;
      m_out        = 1'b0;
      exp_q.delete();
      m_last_acc   = '0;
      m_last_known = 1'b1;
    end
    checkOutput("in_ready", in_ready, rst_n && !m_out && !clear);
    checkOutput("out_valid", out_valid, m_out);
    if (m_out) begin
      if (exp_q.size() == 0) timeoutFail("scoreboard_empty");
      else begin
        checkOutput("out_acc", out_acc, exp_q[0].acc);
        checkOutput("out_ovf", out_ovf, exp_q[0].ovf);
      end
    end else if (m_last_known) begin
      checkOutput("out_acc_hold", out_acc, m_last_acc);
    end
    if (rst_n && !clear && out_valid && out_ready) dut_frames++;
    if (rst_n) begin
      if (clear) begin
        m_total      = '0;
        m_cnt        = 0;
        if (m_out) void'(exp_q.pop_front());
        m_out        = 1'b0;
        m_last_known = 1'b0;
      end else if (m_out) begin
        if (out_ready && exp_q.size() != 0) begin
          e            = exp_q.pop_front();
          m_last_acc   = e.acc;
          m_last_known = 1'b1;
          m_out        = 1'b0;
        end
      end else if (in_valid) begin
        m_total = m_total + WIDE'(in_prod);
        m_cnt++;
        if (m_cnt == N_TERMS) begin
          exp_q.push_back(refFrame(m_total));
          m_out   = 1'b1;
          m_total = '0;
          m_cnt   = 0;
        end
      end
    end
  end

  // Present one product and hold it until the block takes it.
  task automatic applyStimulus(input logic [PROD_W-1:0] p);
    bit accepted;
    int n;
    accepted = 1'b0;
    n = 0;
    in_valid = 1'b1;
    in_prod  = p;
    while (!accepted && n < 200) begin
      @(negedge clk);
      accepted = in_ready;
      @(posedge clk);
      #1;
      n++;
    end
    if (!accepted) timeoutFail("accept_timeout");
    in_valid = 1'b0;
  endtask

  task automatic waitIdle();
    int n;
    n = 0;
    while ((m_out || out_valid) && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 100) timeoutFail("idle_timeout");
  endtask

  task automatic ovfSend(input logic [PROD_W-1:0] p);
    bit accepted;
    int n;
    accepted = 1'b0;
    n = 0;
    o_in_valid = 1'b1;
    o_in_prod  = p;
    while (!accepted && n < 50) begin
      @(negedge clk);
      accepted = o_in_ready;
      @(posedge clk);
      #1;
      n++;
    end
    if (!accepted) timeoutFail("ovf_accept_timeout");
    o_in_valid = 1'b0;
  endtask

  task automatic ovfFrame(input logic [PROD_W-1:0] p0, input logic [PROD_W-1:0] p1);
    logic [PROD_W:0]   total;
    logic [PROD_W-1:0] e_acc;
    logic              e_ovf;
    total = {1'b0, p0} + {1'b0, p1};
    e_ovf = total[PROD_W];
    e_acc = (e_ovf && SAT_EN) ? {PROD_W{1'b1}} : total[PROD_W-1:0];
    ovfSend(p0);
    ovfSend(p1);
    @(negedge clk);
    checkOutput("ovf_out_valid", o_out_valid, 1'b1);
    checkOutput("ovf_out_acc", o_out_acc, e_acc);
    checkOutput("ovf_out_ovf", o_out_ovf, e_ovf);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [PROD_W-1:0] randProd();
    logic [PROD_W-1:0] r;
    for (int i = 0; i < PROD_W / 32; i++) r[i*32 +: 32] = $urandom;
    case ($urandom_range(0, 3))
      0:       r = '1;
      1:       r = PROD_W'($urandom_range(0, 1000));
      default: r = r;
    endcase
    return r;
  endfunction

  initial begin
    logic [PROD_W-1:0] big;
    int n;
    int f0;
    rst_n       = 1'b0;
    clear       = 1'b0;
    in_valid    = 1'b0;
    in_prod     = '0;
    out_ready   = 1'b1;
    o_clear     = 1'b0;
    o_in_valid  = 1'b0;
    o_in_prod   = '0;
    o_out_ready = 1'b1;

    @(posedge clk);
    #1;
    checkOutput("rst_in_ready", in_ready, 1'b0);
    checkOutput("rst_out_valid", out_valid, 1'b0);
    checkOutput("rst_out_acc", out_acc, '0);
    checkOutput("rst_out_ovf", out_ovf, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // 16 ones, then 16 maximum products.
    repeat (N_TERMS) applyStimulus(PROD_W'(1));
    waitIdle();
    repeat (N_TERMS) applyStimulus('1);
    waitIdle();

    // Back-pressure: hold the finished frame for five cycles.
    out_ready = 1'b0;
    repeat (N_TERMS) applyStimulus(PROD_W'(7));
    n = 0;
    while (!out_valid && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 20) timeoutFail("stall_frame_timeout");
    repeat (5) @(posedge clk);
    #1;
    out_ready = 1'b1;
    waitIdle();

    // Abort after seven products; the product seen with clear is discarded.
    f0 = dut_frames;
    repeat (7) applyStimulus(PROD_W'(1));
    in_valid = 1'b1;
    in_prod  = PROD_W'(5);
    clear    = 1'b1;
    @(posedge clk);
    #1;
    clear    = 1'b0;
    in_valid = 1'b0;
    repeat (N_TERMS) applyStimulus(PROD_W'(1));
    waitIdle();
    checkOutput("clear_one_frame", dut_frames - f0, 1);

    // Asynchronous reset in mid-frame.
    repeat (9) applyStimulus(PROD_W'(2));
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_in_ready", in_ready, 1'b0);
    checkOutput("midrst_out_valid", out_valid, 1'b0);
    checkOutput("midrst_out_acc", out_acc, '0);
    checkOutput("midrst_out_ovf", out_ovf, 1'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (N_TERMS) applyStimulus(PROD_W'(3));
    waitIdle();

    // Random traffic with occasional aborts.
    for (int c = 0; c < 400; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_prod   = randProd();
      out_ready = ($urandom_range(0, 2) != 0);
      clear     = ($urandom_range(0, 59) == 0);
      @(posedge clk);
      #1;
    end
    in_valid  = 1'b0;
    clear     = 1'b0;
    out_ready = 1'b1;
    waitIdle();
    clear = 1'b1;
    @(posedge clk);
    #1;
    clear = 1'b0;

    // Overflow instance: a carry out, a clean frame, then a wrap/saturate case.
    big = '0;
    big[PROD_W-1] = 1'b1;
    ovfFrame(big, big);
    ovfFrame(PROD_W'(1), PROD_W'(2));
    ovfFrame('1, PROD_W'(5));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "[TB] watchdog");
  end

endmodule

// File: doc/mac_accum.md
MAC_ACCUM -- requirements
Module: mac_accum

Interface
REQ-001 Parameter PROD_W, default 512, width of each incoming product from the shift-add multiplier stage.
REQ-002 Parameter GUARD, default 16, number of accumulator guard bits above PROD_W.
REQ-003 Parameter N_TERMS, default 16, products summed per output frame; legal range 1..65535.
REQ-004 The accumulator width ACC_W SHALL be PROD_W+GUARD.
REQ-005 clk  input  1  clock; all state updates on rising edge.
REQ-006 rst_n  input  1  reset, asynchronous, active-low.
REQ-007 clear  input  1  synchronous frame abort/restart.
REQ-008 in_valid  input  1  in_prod is valid this cycle.
REQ-009 in_ready  output  1  block accepts in_prod this cycle.
REQ-010 in_prod  input  PROD_W  unsigned product from the multiplier.
REQ-011 out_valid  output  1  out_acc/out_ovf hold a completed frame.
REQ-012 out_ready  input  1  downstream accepts the frame.
REQ-013 out_acc  output  ACC_W  unsigned sum of N_TERMS products.
REQ-014 out_ovf  output  1  frame overflowed ACC_W.

Function
REQ-015 The block SHALL implement two states, ACC and OUT, and SHALL be in ACC after reset.
REQ-016 In ACC, in_ready SHALL equal !clear; in OUT, in_ready SHALL be 0.
REQ-017 A transfer SHALL occur when in_valid and in_ready are both 1 on a rising edge; the block SHALL then add the zero-extended in_prod to acc and increment term count cnt.
REQ-018 When a transfer occurs with cnt == N_TERMS-1, the block SHALL load out_acc with the updated sum, load out_ovf with the updated overflow flag, set out_valid, and enter OUT on the same edge (one-cycle latency from last product to out_valid).
REQ-019 In OUT, out_acc and out_ovf SHALL remain stable until the handshake completes.
REQ-020 When out_valid and out_ready are both 1, the block SHALL clear acc, cnt, and the overflow flag, deassert out_valid, and return to ACC; in_ready SHALL rise on the following cycle (one bubble).
REQ-021 An addition whose carry exceeds ACC_W bits SHALL set a sticky overflow flag for the current frame.
REQ-022 clear SHALL take priority over all handshakes in both states: on a clear edge, acc, cnt, overflow flag, and out_valid SHALL be 0, state SHALL be ACC, and any product presented that cycle SHALL be discarded.
REQ-023 out_acc SHALL retain its last value after the handshake; only out_valid qualifies it.
REQ-024 With N_TERMS == 1, every accepted product SHALL produce one frame.

Reset
REQ-025 On rst_n low, the block SHALL asynchronously force state=ACC, acc=0, cnt=0, overflow flag=0, out_valid=0, out_acc=0, out_ovf=0.
REQ-026 While rst_n is low, in_ready SHALL be 0.
REQ-027 Reset asserted mid-frame or mid-OUT SHALL discard the partial frame, with no output produced.
REQ-028 After rst_n deasserts, in_ready SHALL be 1 from the first rising edge, unless clear is high.

Configuration
REQ-029 With macro MAC_ACCUM_SAT_EN defined, an overflowing addition SHALL saturate acc to all ones, and acc SHALL stay saturated for the rest of the frame.
REQ-030 Without MAC_ACCUM_SAT_EN, acc SHALL wrap modulo 2^ACC_W.
REQ-031 In both builds, out_ovf SHALL report overflow as in REQ-021.

Verification
REQ-032 Default parameters, 16 products of value 1, in_valid held high -> out_valid one cycle after the 16th transfer, out_acc=16, out_ovf=0.
REQ-033 16 products of 2^512-1 -> out_acc=16*(2^512-1), out_ovf=0.
REQ-034 GUARD=0, N_TERMS=2, products 2^511 and 2^511 -> out_ovf=1; out_acc=0 without MAC_ACCUM_SAT_EN, out_acc=2^512-1 with it.
REQ-035 Frame completes with out_ready low for 5 cycles -> out_valid, out_acc, and out_ovf are stable and in_ready=0 throughout; handshake on cycle 6; in_ready=1 on cycle 7.
REQ-036 Clear pulsed after 7 transfers (product 5 presented in the clear cycle), then 16 products of 1 -> exactly one frame, out_acc=16.
REQ-037 rst_n pulsed low after 9 transfers -> all outputs 0 immediately; the next 16 products of 3 -> out_acc=48.
